// File: rtl/seg_display_arbiter.sv
// ============================================================================
//  Module   : seg_display_arbiter
//  Purpose  : Frame-synchronous arbiter and digit scanner that shares one
//             8-digit seven-segment display among three requesters.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module seg_display_arbiter #(
  parameter int SCAN_DIV   = 100000,
  parameter int MIN_FRAMES = 63
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  req,
  input  logic [39:0] data0,
  input  logic [39:0] data1,
  input  logic [39:0] data2,
  output logic [2:0]  grant,
  output logic [7:0]  seg_en,
  output logic [4:0]  glyph,
  output logic [2:0]  digit_idx,
  output logic        frame_tick
);

  localparam int                 c_DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(SCAN_DIV - 1);
  localparam logic [8:0]         c_MIN      = 9'(MIN_FRAMES);
  localparam logic [4:0]         c_BLANK    = 5'h1F;

  logic [c_DIV_W-1:0] r_div_cnt;
  logic [7:0]         r_hold_cnt;
  logic [39:0]        r_frame_buf;

  logic        w_slot_edge;
  logic        w_frame_edge;
  logic [2:0]  w_idx_inc;
  logic [2:0]  w_pri;
  logic        w_owner_req;
  logic [8:0]  w_done;
  logic        w_keep;
  logic [2:0]  w_grant_nxt;
  logic [7:0]  w_hold_nxt;
  logic [39:0] w_buf_nxt;

  assign w_slot_edge  = (r_div_cnt == c_DIV_LAST);
  assign w_frame_edge = w_slot_edge && (digit_idx == 3'd7);
  assign w_idx_inc    = digit_idx + 3'd1;

  // Fixed priority: req[2] beats req[1] beats req[0].
  always_comb begin
    w_pri = 3'b000;
    if (req[2])      w_pri = 3'b100;
    else if (req[1]) w_pri = 3'b010;
    else if (req[0]) w_pri = 3'b001;
  end

  // The frame now ending counts toward the owner's minimum tenure.
  assign w_owner_req = |(req & grant);
  assign w_done      = {1'b0, r_hold_cnt} + 9'd1;
  assign w_keep      = (grant != 3'b000) && w_owner_req && (w_done < c_MIN);

  // Release, idle grant and post-tenure re-arbitration all reduce to w_pri.
  always_comb begin
    w_grant_nxt = w_keep ? grant : w_pri;
    w_hold_nxt  = 8'h00;
    if ((grant != 3'b000) && (w_grant_nxt == grant)) begin
      w_hold_nxt = w_done[8] ? 8'hFF : w_done[7:0];
    end
  end

  always_comb begin
    w_buf_nxt = '1;
    unique case (w_grant_nxt)
      3'b100:  w_buf_nxt = data2;
      3'b010:  w_buf_nxt = data1;
      3'b001:  w_buf_nxt = data0;
      default: w_buf_nxt = '1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt   <= '0;
      digit_idx   <= 3'd0;
      grant       <= 3'b000;
      seg_en      <= 8'h00;
      glyph       <= c_BLANK;
      frame_tick  <= 1'b0;
      r_hold_cnt  <= 8'h00;
      r_frame_buf <= '1;
    end else begin
      frame_tick <= w_frame_edge;
      if (w_slot_edge) begin
        r_div_cnt <= '0;
        digit_idx <= w_idx_inc;
        if (w_frame_edge) begin
          // Ownership, buffer and slot-0 outputs switch together.
          grant       <= w_grant_nxt;
          r_hold_cnt  <= w_hold_nxt;
          r_frame_buf <= w_buf_nxt;
          if (w_grant_nxt != 3'b000) begin
            seg_en <= 8'h01;
            glyph  <= w_buf_nxt[4:0];
          end else begin
            seg_en <= 8'h00;
            glyph  <= c_BLANK;
          end
        end else if (grant != 3'b000) begin
          seg_en <= 8'h01 << w_idx_inc;
          glyph  <= r_frame_buf[5*w_idx_inc +: 5];
        end else begin
          seg_en <= 8'h00;
          glyph  <= c_BLANK;
        end
      end else begin
        r_div_cnt <= r_div_cnt + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seg_display_arbiter.sv
// ============================================================================
//  Module   : tb_seg_display_arbiter
//  Purpose  : Directed scoreboard bench for seg_display_arbiter.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_seg_display_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  req;
  logic [39:0] data0, data1, data2;
  logic [2:0]  grant;
  logic [7:0]  seg_en;
  logic [4:0]  glyph;
  logic [2:0]  digit_idx;
  logic        frame_tick;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [2:0] g;
    logic [7:0] s;
    logic [4:0] gl;
    logic [2:0] idx;
  } exp_t;

  exp_t sb[$];

  seg_display_arbiter #(.SCAN_DIV(4), .MIN_FRAMES(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .data0      (data0),
    .data1      (data1),
    .data2      (data2),
    .grant      (grant),
    .seg_en     (seg_en),
    .glyph      (glyph),
    .digit_idx  (digit_idx),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [39:0] mk(input int base);
    logic [39:0] d;
    for (int i = 0; i < 8; i++) d[5*i +: 5] = 5'(base + i);
    return d;
  endfunction

  task automatic expect_frame(input logic [2:0] g, input logic [39:0] d, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.g   = g;
      e.s   = (g != 3'b000) ? (8'h01 << i) : 8'h00;
      e.gl  = (g != 3'b000) ? d[5*i +: 5] : 5'h1F;
      e.idx = 3'(i);
      sb.push_back(e);
    end
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      n++;
      if (frame_tick) break;
    end
    chk("tick_seen", 32'(frame_tick), 32'd1);
  endtask

  // Samples n slots starting at the cycle after a frame edge; optionally
  // drives new req/data1 right after sampling slot act_slot.
  task automatic check_slots(input int n, input int act_slot,
                             input logic [2:0] a_req, input logic [39:0] a_d1);
    exp_t e;
    for (int s = 0; s < n; s++) begin
      if (s > 0) repeat (4) @(negedge clk);
      chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("grant",     32'(grant),     32'(e.g));
        chk("seg_en",    32'(seg_en),    32'(e.s));
        chk("glyph",     32'(glyph),     32'(e.gl));
        chk("digit_idx", 32'(digit_idx), 32'(e.idx));
      end
      if (s == 0) chk("tick_high", 32'(frame_tick), 32'd1);
      if (s == 1) chk("tick_low",  32'(frame_tick), 32'd0);
      if (s == act_slot) begin
        req   = a_req;
        data1 = a_d1;
      end
    end
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_grant"},     32'(grant),      32'd0);
    chk({pfx, "_seg_en"},    32'(seg_en),     32'd0);
    chk({pfx, "_glyph"},     32'(glyph),      32'h1F);
    chk({pfx, "_digit_idx"}, 32'(digit_idx),  32'd0);
    chk({pfx, "_tick"},      32'(frame_tick), 32'd0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    req   = 3'b000;
    data0 = mk(0);
    data1 = mk(8);
    data2 = mk(16);
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");

    // Idle frame after reset; request owner 0 in slot 7.
    rst_n = 1'b1;
    expect_frame(3'b000, '1, 8);
    wait_tick(n);
    chk("first_tick_latency", 32'(n), 32'd32);
    check_slots(8, 7, 3'b001, data1);

    // Frame A: owner 0; then request 2 as well.
    expect_frame(3'b001, data0, 8);
    wait_tick(n);
    check_slots(8, 7, 3'b101, data1);

    // Frame B: owner 0 retained (done=1 < 2).
    expect_frame(3'b001, data0, 8);
    wait_tick(n);
    check_slots(8, -1, 3'b101, data1);

    // Frame C: switch to owner 2; owner drops mid-frame at slot 2.
    expect_frame(3'b100, data2, 8);
    wait_tick(n);
    check_slots(8, 2, 3'b001, data1);

    // Frame D: pending requester 0 takes over; all requests drop.
    expect_frame(3'b001, data0, 8);
    wait_tick(n);
    check_slots(8, 3, 3'b000, data1);

    // Frame E: idle; request owner 1.
    expect_frame(3'b000, '1, 8);
    wait_tick(n);
    check_slots(8, 7, 3'b010, data1);

    // Frame F: owner 1; data1 changes at slot 3 but stays hidden this frame.
    expect_frame(3'b010, mk(8), 8);
    wait_tick(n);
    check_slots(8, 3, 3'b010, mk(24));

    // Frame G: new data1 visible; reset asserted during slot 5.
    expect_frame(3'b010, mk(24), 6);
    wait_tick(n);
    check_slots(6, -1, 3'b010, data1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Frame H: scanning restarts; first tick 32 cycles after release.
    expect_frame(3'b010, mk(24), 8);
    wait_tick(n);
    chk("post_reset_tick_latency", 32'(n), 32'd32);
    check_slots(8, -1, 3'b010, data1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
